// File: rtl/llapi_n64_pad_map.sv
// LLAPI receiver outputs -> N64 joypad state (buttons, deadzoned/scaled stick) plus rumble stretching.
// Optional: define LLAPI_DPAD_STICK_EN to let the D-pad drive a zero stick axis on digital pad types.
module llapi_n64_pad_map #(
    parameter int unsigned DEADZONE     = 8,
    parameter int unsigned SCALE        = 88,
    parameter int unsigned N64_MAX      = 80,
    parameter int unsigned C_THRESH     = 64,
    parameter int unsigned SYNC_TIMEOUT = 350000,
    parameter int unsigned RUMBLE_HOLD  = 500000
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    input  logic        LLAPI_SYNC,
    input  logic        LLAPI_EN,
    input  logic [7:0]  LLAPI_TYPE,
    input  logic [31:0] LLAPI_BUTTONS,
    input  logic [71:0] LLAPI_ANALOG,
    input  logic        CORE_RUMBLE,
    output logic [15:0] PAD_BUTTONS,
    output logic [7:0]  PAD_X,
    output logic [7:0]  PAD_Y,
    output logic        PAD_VALID,
    output logic        N64_RUMBLE
);

    localparam int unsigned TO_W   = $clog2(SYNC_TIMEOUT + 1);
    localparam int unsigned HOLD_W = $clog2(RUMBLE_HOLD + 1);
    localparam logic [7:0]  DZ8    = 8'(DEADZONE);
    localparam logic [7:0]  SC8    = 8'(SCALE);
    localparam logic [7:0]  MAX8   = 8'(N64_MAX);
    localparam logic [7:0]  C_LO   = 8'(128 - C_THRESH);
    localparam logic [7:0]  C_HI   = 8'(127 + C_THRESH);

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_AXIS_X, S_AXIS_Y, S_COMMIT} state_t;

    state_t            r_state;
    logic              r_sync_meta, r_sync_s, r_sync_d;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_cap_en;
    logic [27:0]       r_cap_btn;
    logic [7:0]        r_cap_ax, r_cap_ay, r_cap_a2x, r_cap_a2y;
    logic [7:0]        r_x, r_y;
    logic              r_rumble_req;
    logic [HOLD_W-1:0] r_hold;

    logic              w_trig;
    logic [7:0]        w_axis_raw, w_mag, w_mag_dz, w_sat, w_axis_res;
    logic [8:0]        w_v, w_v_neg, w_p;
    logic [15:0]       w_prod;
    logic              w_du, w_dd, w_dl, w_dr;
    logic [15:0]       w_btn;
    logic [7:0]        w_fin_x, w_fin_y;
    logic              w_unused;

    assign w_trig = (r_sync_s & ~r_sync_d) | (r_to_cnt == TO_W'(SYNC_TIMEOUT - 1));

    // Single 8x8 multiplier shared by both axes; Y result is negated so "up" is positive.
    always_comb begin
        w_axis_raw = (r_state == S_AXIS_Y) ? r_cap_ay : r_cap_ax;
        w_v        = {1'b0, w_axis_raw} - 9'd128;
        w_v_neg    = 9'd0 - w_v;
        w_mag      = w_v[8] ? w_v_neg[7:0] : w_v[7:0];
        w_mag_dz   = (w_mag > DZ8) ? (w_mag - DZ8) : '0;
        w_prod     = {8'd0, w_mag_dz} * {8'd0, SC8};
        w_p        = w_prod[15:7];
        w_sat      = (w_p > {1'b0, MAX8}) ? MAX8 : w_p[7:0];
        w_axis_res = (w_v[8] ^ (r_state == S_AXIS_Y)) ? (8'd0 - w_sat) : w_sat;
    end

    assign w_du = r_cap_btn[10] | r_cap_btn[27];
    assign w_dd = r_cap_btn[11] | r_cap_btn[26];
    assign w_dl = r_cap_btn[12] | r_cap_btn[25];
    assign w_dr = r_cap_btn[13] | r_cap_btn[24];

    assign w_btn = {r_cap_btn[1], r_cap_btn[0], r_cap_btn[8], r_cap_btn[5],
                    w_du, w_dd, w_dl, w_dr, 2'b00, r_cap_btn[6], r_cap_btn[7],
                    r_cap_btn[2] | (r_cap_a2y < C_LO),
                    r_cap_btn[9] | (r_cap_a2y > C_HI),
                    r_cap_btn[4] | (r_cap_a2x < C_LO),
                    r_cap_btn[3] | (r_cap_a2x > C_HI)};

`ifdef LLAPI_DPAD_STICK_EN
    logic [7:0] r_cap_type;
    logic       w_dpad_type;
    assign w_dpad_type = (r_cap_type == 8'd18) || (r_cap_type == 8'd21) ||
                         (r_cap_type == 8'd22) || (r_cap_type == 8'd27);
    always_comb begin
        w_fin_x = r_x;
        w_fin_y = r_y;
        if (w_dpad_type && (r_x == '0))
            w_fin_x = (w_dl & ~w_dr) ? (8'd0 - MAX8) : ((w_dr & ~w_dl) ? MAX8 : '0);
        if (w_dpad_type && (r_y == '0))
            w_fin_y = (w_du & ~w_dd) ? MAX8 : ((w_dd & ~w_du) ? (8'd0 - MAX8) : '0);
    end
    assign w_unused = ^{LLAPI_BUTTONS[31:28], LLAPI_ANALOG[71:40], LLAPI_ANALOG[23:16],
                        r_cap_btn[23:14]};
`else
    assign w_fin_x  = r_x;
    assign w_fin_y  = r_y;
    assign w_unused = ^{LLAPI_TYPE, LLAPI_BUTTONS[31:28], LLAPI_ANALOG[71:40],
                        LLAPI_ANALOG[23:16], r_cap_btn[23:14]};
`endif

    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_sync_meta <= 1'b0;
            r_sync_s    <= 1'b0;
            r_sync_d    <= 1'b0;
            r_to_cnt    <= '0;
            r_cap_en    <= 1'b0;
            r_cap_btn   <= '0;
            r_cap_ax    <= '0;
            r_cap_ay    <= '0;
            r_cap_a2x   <= '0;
            r_cap_a2y   <= '0;
`ifdef LLAPI_DPAD_STICK_EN
            r_cap_type  <= '0;
`endif
            r_x         <= '0;
            r_y         <= '0;
            PAD_BUTTONS <= '0;
            PAD_X       <= '0;
            PAD_Y       <= '0;
            PAD_VALID   <= 1'b0;
        end else begin
            r_sync_meta <= LLAPI_SYNC;
            r_sync_s    <= r_sync_meta;
            r_sync_d    <= r_sync_s;
            r_to_cnt    <= w_trig ? '0 : r_to_cnt + TO_W'(1);
            case (r_state)
                S_IDLE: if (w_trig) r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_cap_en  <= LLAPI_EN;
                    r_cap_btn <= LLAPI_BUTTONS[27:0];
                    r_cap_ax  <= LLAPI_ANALOG[7:0];
                    r_cap_ay  <= LLAPI_ANALOG[15:8];
                    r_cap_a2x <= LLAPI_ANALOG[31:24];
                    r_cap_a2y <= LLAPI_ANALOG[39:32];
`ifdef LLAPI_DPAD_STICK_EN
                    r_cap_type <= LLAPI_TYPE;
`endif
                    r_state   <= S_AXIS_X;
                end
                S_AXIS_X: begin
                    r_x     <= w_axis_res;
                    r_state <= S_AXIS_Y;
                end
                S_AXIS_Y: begin
                    r_y     <= w_axis_res;
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    PAD_VALID   <= r_cap_en;
                    PAD_BUTTONS <= r_cap_en ? w_btn : '0;
                    PAD_X       <= r_cap_en ? w_fin_x : '0;
                    PAD_Y       <= r_cap_en ? w_fin_y : '0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Hold counter reloads while the request is high, then counts out the stretch.
    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            r_rumble_req <= 1'b0;
            r_hold       <= '0;
            N64_RUMBLE   <= 1'b0;
        end else begin
            r_rumble_req <= CORE_RUMBLE;
            if (!LLAPI_EN) begin
                r_hold     <= '0;
                N64_RUMBLE <= 1'b0;
            end else if (r_rumble_req) begin
                r_hold     <= HOLD_W'(RUMBLE_HOLD);
                N64_RUMBLE <= 1'b1;
            end else if (r_hold != '0) begin
                r_hold     <= r_hold - HOLD_W'(1);
                N64_RUMBLE <= 1'b1;
            end else begin
                N64_RUMBLE <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_llapi_n64_pad_map.sv
// Directed bench for llapi_n64_pad_map with shortened sync timeout and rumble hold.
module tb_llapi_n64_pad_map;

    localparam int unsigned TB_TIMEOUT = 1000;
    localparam int unsigned TB_HOLD    = 100;

    logic        CLK_50M = 1'b0;
    logic        RESET = 1'b1;
    logic        LLAPI_SYNC = 1'b0;
    logic        LLAPI_EN = 1'b0;
    logic [7:0]  LLAPI_TYPE = '0;
    logic [31:0] LLAPI_BUTTONS = '0;
    logic [71:0] LLAPI_ANALOG = '0;
    logic        CORE_RUMBLE = 1'b0;
    logic [15:0] PAD_BUTTONS;
    logic [7:0]  PAD_X, PAD_Y;
    logic        PAD_VALID, N64_RUMBLE;

    int n_checks = 0;
    int n_fail   = 0;

    llapi_n64_pad_map #(.SYNC_TIMEOUT(TB_TIMEOUT), .RUMBLE_HOLD(TB_HOLD)) dut (
        .CLK_50M(CLK_50M), .RESET(RESET), .LLAPI_SYNC(LLAPI_SYNC), .LLAPI_EN(LLAPI_EN),
        .LLAPI_TYPE(LLAPI_TYPE), .LLAPI_BUTTONS(LLAPI_BUTTONS), .LLAPI_ANALOG(LLAPI_ANALOG),
        .CORE_RUMBLE(CORE_RUMBLE), .PAD_BUTTONS(PAD_BUTTONS), .PAD_X(PAD_X), .PAD_Y(PAD_Y),
        .PAD_VALID(PAD_VALID), .N64_RUMBLE(N64_RUMBLE)
    );

    always #10 CLK_50M = ~CLK_50M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic [7:0] typ, input logic [31:0] btn,
                          input logic [7:0] ax, input logic [7:0] ay,
                          input logic [7:0] a2x, input logic [7:0] a2y);
        LLAPI_EN      = en;
        LLAPI_TYPE    = typ;
        LLAPI_BUTTONS = btn;
        LLAPI_ANALOG  = {32'h0, a2y, a2x, 8'h00, ay, ax};
    endtask

    task automatic snap();
        @(negedge CLK_50M) LLAPI_SYNC = 1'b1;
        @(negedge CLK_50M) LLAPI_SYNC = 1'b0;
        repeat (10) @(negedge CLK_50M);
    endtask

    initial begin
        int n;
        bit seen;
        repeat (3) @(negedge CLK_50M);
        chk("rst_btn", 32'(PAD_BUTTONS), 32'h0);
        chk("rst_x", 32'(PAD_X), 32'h0);
        chk("rst_y", 32'(PAD_Y), 32'h0);
        chk("rst_valid", 32'(PAD_VALID), 32'h0);
        chk("rst_rumble", 32'(N64_RUMBLE), 32'h0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK_50M);

        // Latency: outputs change on the 7th edge after SYNC rises (2 sync flops + 5).
        set_in(1'b1, 8'd0, 32'h0, 8'h80, 8'h80, 8'h80, 8'h80);
        LLAPI_SYNC = 1'b1;
        @(negedge CLK_50M) LLAPI_SYNC = 1'b0;
        repeat (5) @(negedge CLK_50M);
        chk("lat_valid_pre", 32'(PAD_VALID), 32'h0);
        @(negedge CLK_50M);
        chk("lat_valid_post", 32'(PAD_VALID), 32'h1);
        chk("centre_x", 32'(PAD_X), 32'h0);
        chk("centre_y", 32'(PAD_Y), 32'h0);
        chk("centre_btn", 32'(PAD_BUTTONS), 32'h0);

        set_in(1'b1, 8'd0, 32'h0, 8'hFF, 8'h00, 8'h80, 8'h80);
        snap();
        chk("x_ff_sat", 32'(PAD_X), 32'h50);
        chk("y_00_up", 32'(PAD_Y), 32'h50);
        set_in(1'b1, 8'd0, 32'h0, 8'h00, 8'hA0, 8'h80, 8'h80);
        snap();
        chk("x_00_sat", 32'(PAD_X), 32'hB0);
        chk("y_a0_down", 32'(PAD_Y), 32'hF0);
        set_in(1'b1, 8'd0, 32'h0, 8'hA0, 8'h88, 8'h80, 8'h80);
        snap();
        chk("x_a0", 32'(PAD_X), 32'h10);
        chk("y_88_dz", 32'(PAD_Y), 32'h0);
        set_in(1'b1, 8'd0, 32'h0, 8'h88, 8'h78, 8'h80, 8'h80);
        snap();
        chk("x_88_dz", 32'(PAD_X), 32'h0);
        chk("y_78_dz", 32'(PAD_Y), 32'h0);

        set_in(1'b1, 8'd0, (32'd1 << 1) | (32'd1 << 5) | (32'd1 << 27), 8'h80, 8'h80, 8'hF0, 8'h80);
        snap();
        chk("btn_a_st_du_cr", 32'(PAD_BUTTONS), 32'h9801);
        set_in(1'b1, 8'd0, 32'h0100_01C1, 8'h80, 8'h80, 8'h3F, 8'hC0);
        snap();
        chk("btn_b_z_l_r_dr_cl_cd", 32'(PAD_BUTTONS), 32'h6136);
        set_in(1'b1, 8'd0, 32'h0000_3E1C, 8'h80, 8'h80, 8'h40, 8'hBF);
        snap();
        chk("btn_digital_c_edge", 32'(PAD_BUTTONS), 32'h0F0F);
        set_in(1'b1, 8'd0, 32'h0600_0000, 8'h80, 8'h80, 8'h80, 8'h3F);
        snap();
        chk("btn_dl_dd_cu", 32'(PAD_BUTTONS), 32'h0608);

        // Second rise two cycles after the first must be dropped, not queued.
        set_in(1'b1, 8'd0, 32'h0, 8'hFF, 8'h80, 8'h80, 8'h80);
        @(negedge CLK_50M) LLAPI_SYNC = 1'b1;
        @(negedge CLK_50M) LLAPI_SYNC = 1'b0;
        @(negedge CLK_50M) LLAPI_SYNC = 1'b1;
        @(negedge CLK_50M) LLAPI_SYNC = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK_50M);
            if (PAD_X == 8'h50) seen = 1'b1;
        end
        chk("dbl_first_commit", 32'(seen), 32'h1);
        set_in(1'b1, 8'd0, 32'h0, 8'h00, 8'h80, 8'h80, 8'h80);
        repeat (15) @(negedge CLK_50M);
        chk("dbl_no_second", 32'(PAD_X), 32'h50);

        // Self-trigger lands exactly SYNC_TIMEOUT cycles after the previous commit.
        set_in(1'b1, 8'd0, 32'h0, 8'h88, 8'h80, 8'h80, 8'h80);
        @(negedge CLK_50M) LLAPI_SYNC = 1'b1;
        @(negedge CLK_50M) LLAPI_SYNC = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK_50M);
            if (PAD_X == 8'h00) seen = 1'b1;
        end
        chk("to_ref_commit", 32'(seen), 32'h1);
        set_in(1'b1, 8'd0, 32'h0, 8'hA0, 8'h80, 8'h80, 8'h80);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 1100) begin
            @(negedge CLK_50M);
            n++;
            if (PAD_X == 8'h10) seen = 1'b1;
        end
        chk("to_fired", 32'(seen), 32'h1);
        chk("to_cycles", 32'(n), 32'(TB_TIMEOUT));

        // Rumble stretch: 10 request cycles + hold.
        @(negedge CLK_50M) CORE_RUMBLE = 1'b1;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge CLK_50M);
            if (i == 10) CORE_RUMBLE = 1'b0;
            if (N64_RUMBLE) n++;
        end
        chk("rumble_len", 32'(n), 32'(10 + TB_HOLD));
        @(negedge CLK_50M) CORE_RUMBLE = 1'b1;
        repeat (3) @(negedge CLK_50M);
        CORE_RUMBLE = 1'b0;
        repeat (20) @(negedge CLK_50M);
        chk("rumble_hold", 32'(N64_RUMBLE), 32'h1);
        LLAPI_EN = 1'b0;
        @(negedge CLK_50M);
        chk("rumble_en_drop", 32'(N64_RUMBLE), 32'h0);
        LLAPI_EN = 1'b1;
        repeat (2) @(negedge CLK_50M);
        chk("rumble_cleared", 32'(N64_RUMBLE), 32'h0);

        set_in(1'b1, 8'd0, 32'h2, 8'hFF, 8'h00, 8'h80, 8'h80);
        snap();
        chk("pre_disc_valid", 32'(PAD_VALID), 32'h1);
        set_in(1'b0, 8'd0, 32'h0800_0023, 8'hFF, 8'h00, 8'hF0, 8'h80);
        snap();
        chk("disc_valid", 32'(PAD_VALID), 32'h0);
        chk("disc_btn", 32'(PAD_BUTTONS), 32'h0);
        chk("disc_x", 32'(PAD_X), 32'h0);
        chk("disc_y", 32'(PAD_Y), 32'h0);

        // Reset in AXIS_X: nothing from the in-flight snapshot may appear.
        set_in(1'b1, 8'd0, 32'h2, 8'hFF, 8'h00, 8'h80, 8'h80);
        snap();
        chk("pre_rst_x", 32'(PAD_X), 32'h50);
        @(negedge CLK_50M) LLAPI_SYNC = 1'b1;
        @(negedge CLK_50M) LLAPI_SYNC = 1'b0;
        repeat (3) @(negedge CLK_50M);
        RESET = 1'b1;
        @(negedge CLK_50M);
        chk("midrst_x", 32'(PAD_X), 32'h0);
        chk("midrst_btn", 32'(PAD_BUTTONS), 32'h0);
        RESET = 1'b0;
        repeat (10) @(negedge CLK_50M);
        chk("midrst_no_commit", 32'(PAD_VALID), 32'h0);

        set_in(1'b1, 8'd27, 32'h0000_1000, 8'h80, 8'h80, 8'h80, 8'h80);
        snap();
        chk("dpad_btn", 32'(PAD_BUTTONS), 32'h0200);
`ifdef LLAPI_DPAD_STICK_EN
        chk("dpad_x", 32'(PAD_X), 32'hB0);
`else
        chk("dpad_x", 32'(PAD_X), 32'h0);
`endif
        set_in(1'b1, 8'd5, 32'h0000_0400, 8'h80, 8'h80, 8'h80, 8'h80);
        snap();
        chk("dpad_other_type_y", 32'(PAD_Y), 32'h0);
        set_in(1'b1, 8'd18, 32'h0000_3000, 8'h80, 8'h80, 8'h80, 8'h80);
        snap();
        chk("dpad_opposed_x", 32'(PAD_X), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
